// File: rtl/pw_cracker_pkg.sv
// Shared types and constants for the password candidate path.
// CAND_DIGITS_EN widens the symbol set from 26 letters to letters plus digits.
package pw_cracker_pkg;

  localparam int SYM_W = 6;
`ifdef CAND_DIGITS_EN
  localparam int SYM_COUNT = 36;
`else
  localparam int SYM_COUNT = 26;
`endif
  localparam logic [SYM_W-1:0] SYM_MAX        = SYM_W'(SYM_COUNT - 1);
  localparam logic [7:0]       SYM_ALPHA_BASE = 8'h61;
  localparam logic [7:0]       SYM_DIGIT_BASE = 8'h30;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/pw_sym_map.sv
// Maps a symbol index to its ASCII byte: 0..25 -> 'a'..'z'.
// With CAND_DIGITS_EN, 26..35 -> '0'..'9'.
module pw_sym_map
  import pw_cracker_pkg::*;
(
  input  logic [SYM_W-1:0] idx,
  output logic [7:0]       ch
);

  always_comb begin
    ch = SYM_ALPHA_BASE + 8'(idx);
`ifdef CAND_DIGITS_EN
    if (idx > 6'd25) begin
      ch = SYM_DIGIT_BASE + 8'(idx) - 8'd26;
    end
`endif
  end

endmodule

// File: rtl/pw_candidate_gen.sv
// Exhaustive password candidate generator (shortest length first, odometer order)
// with a valid/ready output. CAND_DIGITS_EN adds '0'..'9' to the symbol set.
module pw_candidate_gen
  import pw_cracker_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [5:0]   start_len,
  input  logic         abort,
  input  logic         cand_ready,
  output logic         cand_valid,
  output logic [255:0] cand_data,
  output logic [63:0]  cand_length,
  output logic [63:0]  cand_count,
  output logic         busy,
  output logic         done
);

  localparam logic [5:0] MAX_LEN_L = 6'(MAX_LEN);

  state_t           state_reg, state_next;
  logic [SYM_W-1:0] idx_reg  [MAX_LEN];
  logic [SYM_W-1:0] idx_next [MAX_LEN];
  logic [SYM_W-1:0] idx_inc  [MAX_LEN];
  logic [5:0]       len_reg, len_next;
  logic             valid_reg, valid_next;
  logic [63:0]      count_reg, count_next;
  logic [MAX_LEN-1:0]   lane_pass;
  logic [8*MAX_LEN-1:0] packed_data;
  logic             overflow;

  // Lane gi is byte gi; inactive lanes pass the carry through untouched.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_lane
      logic       lane_on;
      logic       lane_max;
      logic       carry_in;
      logic [7:0] ch;

      assign lane_on       = 6'(gi) < len_reg;
      assign lane_max      = (idx_reg[gi] == SYM_MAX);
      assign lane_pass[gi] = !lane_on || lane_max;

      if (gi == 0) begin : g_first
        assign carry_in = 1'b1;
      end else begin : g_rest
        assign carry_in = &lane_pass[gi-1:0];
      end

      assign idx_inc[gi] = (lane_on && carry_in)
                         ? (lane_max ? '0 : idx_reg[gi] + 6'd1)
                         : idx_reg[gi];

      pw_sym_map u_sym_map (
        .idx (idx_reg[gi]),
        .ch  (ch)
      );

      assign packed_data[8*gi +: 8] = lane_on ? ch : 8'h00;
    end
  endgenerate

  assign overflow = &lane_pass;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    len_next   = len_reg;
    valid_next = valid_reg;
    count_next = count_reg;
    if (abort) begin
      state_next = IDLE;
      valid_next = 1'b0;
      count_next = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = EMIT;
            len_next   = (start_len == 6'd0) ? 6'd1 : start_len;
            count_next = '0;
            for (int i = 0; i < MAX_LEN; i++) idx_next[i] = '0;
          end
        end
        EMIT: begin
          // First EMIT cycle only qualifies the freshly loaded length.
          if (!valid_reg) begin
            if (len_reg > MAX_LEN_L) state_next = DONE;
            else                     valid_next = 1'b1;
          end else if (cand_ready) begin
            count_next = count_reg + 64'd1;
            idx_next   = idx_inc;
            if (overflow) begin
              if (len_reg == MAX_LEN_L) begin
                valid_next = 1'b0;
                state_next = DONE;
              end else begin
                len_next = len_reg + 6'd1;
              end
            end
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      valid_reg <= 1'b0;
      count_reg <= '0;
      for (int i = 0; i < MAX_LEN; i++) idx_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
      idx_reg   <= idx_next;
    end
  end

  assign cand_valid  = valid_reg;
  assign cand_data   = valid_reg ? 256'(packed_data) : '0;
  assign cand_length = valid_reg ? {58'd0, len_reg} : 64'd0;
  assign cand_count  = count_reg;
  assign busy        = (state_reg == EMIT);
  assign done        = (state_reg == DONE);

endmodule

// File: tb/tb_pw_candidate_gen.sv
// Directed bench for pw_candidate_gen with MAX_LEN=2; expectations follow
// CAND_DIGITS_EN when it is defined for the build.
module tb_pw_candidate_gen;

  localparam int MAX_LEN = 2;
  localparam logic [255:0] ZERO = 256'd0;
  localparam logic [255:0] ONE  = 256'd1;
`ifdef CAND_DIGITS_EN
  localparam int           TOTAL       = 1332;
  localparam logic [255:0] EXP_27      = 256'h30;
  localparam logic [255:0] EXP_27_LEN  = 256'd1;
  localparam logic [255:0] EXP_37      = 256'h6161;
  localparam logic [255:0] EXP_LAST    = 256'h3939;
`else
  localparam int           TOTAL       = 702;
  localparam logic [255:0] EXP_27      = 256'h6161;
  localparam logic [255:0] EXP_27_LEN  = 256'd2;
  localparam logic [255:0] EXP_37      = 256'h616B;
  localparam logic [255:0] EXP_LAST    = 256'h7A7A;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   start_len;
  logic         abort;
  logic         cand_ready;
  logic         cand_valid;
  logic [255:0] cand_data;
  logic [63:0]  cand_length;
  logic [63:0]  cand_count;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pw_candidate_gen #(.MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_len   (start_len),
    .abort       (abort),
    .cand_ready  (cand_ready),
    .cand_valid  (cand_valid),
    .cand_data   (cand_data),
    .cand_length (cand_length),
    .cand_count  (cand_count),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start; returns one cycle later, when the first candidate should be up.
  task automatic do_start(input logic [5:0] len);
    start     = 1'b1;
    start_len = len;
    tick();
    start = 1'b0;
    check("valid_not_yet", 256'(cand_valid), ZERO);
    tick();
  endtask

  task automatic run_until_count(input int k, input string tag);
    int cyc = 0;
    while (cand_count < 64'(k) && cyc < 200) begin
      tick();
      cyc++;
    end
    check(tag, 256'(cand_count), 256'(k));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 256'(cand_valid), ZERO);
    check({tag, "_data"},  cand_data, ZERO);
    check({tag, "_len"},   256'(cand_length), ZERO);
    check({tag, "_count"}, 256'(cand_count), ZERO);
    check({tag, "_busy"},  256'(busy), ZERO);
    check({tag, "_done"},  256'(done), ZERO);
  endtask

  task automatic full_run();
    int n = 0;
    int dones = 0;
    int last_cyc = -10;
    int done_cyc = -1;
    logic [255:0] last = '0;
    do_start(6'd1);
    for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
      if (cand_valid) begin
        n++;
        last = cand_data;
        last_cyc = cyc;
        check("count_tracks", 256'(cand_count), 256'(n - 1));
        if (n == 1) begin
          check("cand1", cand_data, 256'h61);
          check("cand1_len", 256'(cand_length), ONE);
          check("busy_emit", 256'(busy), ONE);
        end
        if (n == 2) check("cand2", cand_data, 256'h62);
        if (n == 3) check("cand3", cand_data, 256'h63);
        if (n == 27) begin
          check("cand27", cand_data, EXP_27);
          check("cand27_len", 256'(cand_length), EXP_27_LEN);
        end
        if (n == 37) check("cand37", cand_data, EXP_37);
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        check("done_valid_low", 256'(cand_valid), ZERO);
      end
      tick();
    end
    check("done_pulses", 256'(dones), ONE);
    check("done_follows_last", 256'(done_cyc - last_cyc), ONE);
    check("total_cands", 256'(n), 256'(TOTAL));
    check("last_cand", last, EXP_LAST);
    check("final_count", 256'(cand_count), 256'(TOTAL));
    check("done_one_cycle", 256'(done), ZERO);
    tick();
    tick();
    check("count_holds", 256'(cand_count), 256'(TOTAL));
    check("idle_valid", 256'(cand_valid), ZERO);
    $display("full run: %0d candidates, last 0x%0h, count %0d", n, last, cand_count);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    start_len  = 6'd0;
    abort      = 1'b0;
    cand_ready = 1'b1;
    #2;
    check_all_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();

    full_run();

    // Oversized start length ends without emitting.
    start     = 1'b1;
    start_len = 6'd3;
    tick();
    start = 1'b0;
    check("ovf_done_early", 256'(done), ZERO);
    check("ovf_valid0", 256'(cand_valid), ZERO);
    tick();
    check("ovf_done", 256'(done), ONE);
    check("ovf_valid1", 256'(cand_valid), ZERO);
    check("ovf_count", 256'(cand_count), ZERO);
    tick();
    check("ovf_done_low", 256'(done), ZERO);
    check("ovf_valid2", 256'(cand_valid), ZERO);
    $display("oversize start: done pulse seen two cycles after start");

    // Backpressure on the 5th candidate, then start while busy.
    do_start(6'd1);
    for (int i = 1; i < 5; i++) tick();
    check("bp_5th", cand_data, 256'h65);
    cand_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_data", cand_data, 256'h65);
      check("bp_hold_valid", 256'(cand_valid), ONE);
      check("bp_hold_len", 256'(cand_length), ONE);
    end
    check("bp_count", 256'(cand_count), 256'd4);
    cand_ready = 1'b1;
    tick();
    check("bp_after", cand_data, 256'h66);
    check("bp_after_count", 256'(cand_count), 256'd5);
    start     = 1'b1;
    start_len = 6'd2;
    tick();
    start = 1'b0;
    check("busy_start_ignored", cand_data, 256'h67);
    check("busy_start_len", 256'(cand_length), ONE);
    tick();
    check("bp_next", cand_data, 256'h68);
    $display("backpressure: held 0x65 for 3 cycles, resumed at 0x66");

    // Asynchronous reset mid-stream.
    run_until_count(10, "pre_reset_count");
    #3 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_no_done", 256'(done), ZERO);
    end
    do_start(6'd1);
    check("restart_data", cand_data, 256'h61);
    check("restart_count", 256'(cand_count), ZERO);
    $display("reset mid-stream: outputs cleared, restart at 0x61");

    // Abort mid-stream.
    run_until_count(10, "pre_abort_count");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_all_zero("abort");
    tick();
    check("abort_no_done", 256'(done), ZERO);
    do_start(6'd0);
    check("len0_data", cand_data, 256'h61);
    check("len0_len", 256'(cand_length), ONE);
    check("len0_count", 256'(cand_count), ZERO);
    $display("abort mid-stream: outputs cleared, restart with start_len=0 at 0x61");

    // Abort beats start in the same cycle.
    abort = 1'b1;
    tick();
    start     = 1'b1;
    start_len = 6'd1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_over_start_busy", 256'(busy), ZERO);
    tick();
    check("abort_over_start_valid", 256'(cand_valid), ZERO);
    $display("abort with start: stayed idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
